// File: rtl/wb_stage_if.sv
// Writeback stage bus: pipeline-side inputs and register-file-side outputs of wb_stage.
// The master modport drives the stage; the slave modport is the stage itself.
interface wb_stage_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
) ();
   localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned XW    = (NUM_SRC > 2) ? (NUM_SRC - 2) * XLEN : XLEN;

   logic                  VALID_IN;
   logic                  STALL_IN;
   logic                  FLUSH_IN;
   logic [SEL_W-1:0]      CRT_WB_IN;
   logic [XLEN-1:0]       DATA_M;
   logic [XLEN-1:0]       DATA_E;
   logic [XW-1:0]         DATA_X;
   logic [2:0]            LOAD_FMT;
   logic [1:0]            ADDR_LO;
   logic [REG_ADDR_W-1:0] RD_IN;
   logic                  REGWRITE_IN;

   logic                  RF_WE;
   logic [REG_ADDR_W-1:0] RF_ADDR;
   logic [XLEN-1:0]       RF_DATA;
   logic                  VALID_OUT;
   logic                  MISALIGN_ERR;
   logic [CNT_W-1:0]      RETIRE_CNT;

   modport master (
      output VALID_IN, STALL_IN, FLUSH_IN, CRT_WB_IN, DATA_M, DATA_E, DATA_X,
             LOAD_FMT, ADDR_LO, RD_IN, REGWRITE_IN,
      input  RF_WE, RF_ADDR, RF_DATA, VALID_OUT, MISALIGN_ERR, RETIRE_CNT
   );

   modport slave (
      input  VALID_IN, STALL_IN, FLUSH_IN, CRT_WB_IN, DATA_M, DATA_E, DATA_X,
             LOAD_FMT, ADDR_LO, RD_IN, REGWRITE_IN,
      output RF_WE, RF_ADDR, RF_DATA, VALID_OUT, MISALIGN_ERR, RETIRE_CNT
   );
endinterface

// File: rtl/wb_stage.sv
// Registered RV32I writeback stage: source select, load formatting, x0 suppression,
// misaligned-load detection, valid/stall/flush register and retired-write counter.
module wb_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
) (
   input logic     CLK,
   input logic     RST_N,
   wb_stage_if.slave wb
);
   localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [2:0] {
      F_LB  = 3'b000,
      F_LH  = 3'b001,
      F_LW  = 3'b010,
      F_LBU = 3'b100,
      F_LHU = 3'b101
   } load_fmt_e;

   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [XLEN-1:0]       ld_data;
   logic                  ld_err;
   logic [XLEN-1:0]       src_data;
   logic                  src_err;

   logic                  valid_q, valid_d;
   logic                  we_q,    we_d;
   logic                  err_q,   err_d;
   logic [REG_ADDR_W-1:0] addr_q,  addr_d;
   logic [XLEN-1:0]       data_q,  data_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;

   // Load formatting; any error forces the data to zero.
   always_comb begin
      byte_lane = '0;
      ld_data   = '0;
      ld_err    = 1'b0;
      case (wb.ADDR_LO)
         2'd0:    byte_lane = wb.DATA_M[7:0];
         2'd1:    byte_lane = wb.DATA_M[15:8];
         2'd2:    byte_lane = wb.DATA_M[23:16];
         default: byte_lane = wb.DATA_M[31:24];
      endcase
      half_lane = wb.ADDR_LO[1] ? wb.DATA_M[31:16] : wb.DATA_M[15:0];
      case (wb.LOAD_FMT)
         F_LB:  ld_data = XLEN'($signed(byte_lane));
         F_LBU: ld_data = XLEN'(byte_lane);
         F_LH: begin
            if (wb.ADDR_LO[0]) ld_err  = 1'b1;
            else               ld_data = XLEN'($signed(half_lane));
         end
         F_LHU: begin
            if (wb.ADDR_LO[0]) ld_err  = 1'b1;
            else               ld_data = XLEN'(half_lane);
         end
         F_LW: begin
            if (wb.ADDR_LO != 2'b00) ld_err  = 1'b1;
            else                     ld_data = XLEN'(wb.DATA_M[31:0]);
         end
         default: ld_err = 1'b1;
      endcase
   end

   // Out-of-range selects fall through with zero data.
   always_comb begin
      src_data = '0;
      src_err  = 1'b0;
      if (wb.CRT_WB_IN == '0) begin
         src_data = ld_data;
         src_err  = ld_err;
      end else if (wb.CRT_WB_IN == SEL_W'(1)) begin
         src_data = wb.DATA_E;
      end else begin
         for (int unsigned k = 2; k < NUM_SRC; k++) begin
            if (wb.CRT_WB_IN == SEL_W'(k)) src_data = wb.DATA_X[(k-2)*XLEN +: XLEN];
         end
      end
   end

   // Flush beats stall; the error pulse never survives a non-capturing edge.
   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (wb.FLUSH_IN) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!wb.STALL_IN) begin
         valid_d = wb.VALID_IN;
         addr_d  = wb.RD_IN;
         data_d  = src_data;
         we_d    = wb.VALID_IN & wb.REGWRITE_IN & (wb.RD_IN != '0) & ~src_err;
         err_d   = wb.VALID_IN & src_err;
         if (we_d) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wb.RF_WE        = we_q;
   assign wb.RF_ADDR      = addr_q;
   assign wb.RF_DATA      = data_q;
   assign wb.VALID_OUT    = valid_q;
   assign wb.MISALIGN_ERR = err_q;
   assign wb.RETIRE_CNT   = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage: a default instance plus a NUM_SRC=3, CNT_W=4
// instance sharing the same stimulus (out-of-range select and counter wrap).
module tb_wb_stage;
   localparam logic [31:0] DM = 32'h80FF7F01;
   localparam logic [31:0] X0 = 32'hBEEF0001;
   localparam logic [31:0] X1 = 32'hCAFE0002;

   logic CLK;
   logic RST_N;

   wb_stage_if #(.XLEN(32), .NUM_SRC(4), .REG_ADDR_W(5), .CNT_W(32)) if0 ();
   wb_stage_if #(.XLEN(32), .NUM_SRC(3), .REG_ADDR_W(5), .CNT_W(4))  if4 ();

   wb_stage #(.XLEN(32), .NUM_SRC(4), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .wb(if0)
   );
   wb_stage #(.XLEN(32), .NUM_SRC(3), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
      .CLK(CLK), .RST_N(RST_N), .wb(if4)
   );

   assign if4.VALID_IN    = if0.VALID_IN;
   assign if4.STALL_IN    = if0.STALL_IN;
   assign if4.FLUSH_IN    = if0.FLUSH_IN;
   assign if4.CRT_WB_IN   = if0.CRT_WB_IN;
   assign if4.DATA_M      = if0.DATA_M;
   assign if4.DATA_E      = if0.DATA_E;
   assign if4.DATA_X      = if0.DATA_X[31:0];
   assign if4.LOAD_FMT    = if0.LOAD_FMT;
   assign if4.ADDR_LO     = if0.ADDR_LO;
   assign if4.RD_IN       = if0.RD_IN;
   assign if4.REGWRITE_IN = if0.REGWRITE_IN;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        stall, flush, valid, rw;
      logic [1:0]  sel;
      logic [31:0] dm, de;
      logic [2:0]  fmt;
      logic [1:0]  alo;
      logic [4:0]  rd;
      logic        ev, ewe, eerr;
      logic [4:0]  eaddr;
      logic [31:0] edata;
      logic [31:0] ecnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic st, input logic fl, input logic v, input logic rw,
                      input logic [1:0] sel, input logic [31:0] dm, input logic [31:0] de,
                      input logic [2:0] fmt, input logic [1:0] alo, input logic [4:0] rd,
                      input logic ev, input logic ewe, input logic eerr,
                      input logic [4:0] eaddr, input logic [31:0] edata, input logic [31:0] ecnt);
      vec_t t;
      t.stall = st;  t.flush = fl;  t.valid = v;  t.rw = rw;   t.sel = sel;
      t.dm = dm;     t.de = de;     t.fmt = fmt;  t.alo = alo; t.rd = rd;
      t.ev = ev;     t.ewe = ewe;   t.eerr = eerr;
      t.eaddr = eaddr; t.edata = edata; t.ecnt = ecnt;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                        input logic [1:0] sel, input logic [31:0] dm, input logic [31:0] de,
                        input logic [2:0] fmt, input logic [1:0] alo, input logic [4:0] rd);
      if0.STALL_IN = st;  if0.FLUSH_IN = fl;  if0.VALID_IN = v;  if0.REGWRITE_IN = rw;
      if0.CRT_WB_IN = sel; if0.DATA_M = dm;   if0.DATA_E = de;
      if0.LOAD_FMT = fmt; if0.ADDR_LO = alo;  if0.RD_IN = rd;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " we"},    32'(if0.RF_WE),        32'd0);
      chk({tag, " addr"},  32'(if0.RF_ADDR),      32'd0);
      chk({tag, " data"},  if0.RF_DATA,           32'd0);
      chk({tag, " valid"}, 32'(if0.VALID_OUT),    32'd0);
      chk({tag, " err"},   32'(if0.MISALIGN_ERR), 32'd0);
      chk({tag, " cnt"},   if0.RETIRE_CNT,        32'd0);
      chk({tag, " w4 we"},    32'(if4.RF_WE),        32'd0);
      chk({tag, " w4 data"},  if4.RF_DATA,           32'd0);
      chk({tag, " w4 valid"}, 32'(if4.VALID_OUT),    32'd0);
      chk({tag, " w4 cnt"},   32'(if4.RETIRE_CNT),   32'd0);
   endtask

   initial begin
      //  st fl v rw sel dm  de            fmt     alo rd | ev we er addr data          cnt
      add(0, 0, 1, 1, 1, 0,  32'h12345678, 3'b000, 0, 5,   1, 1, 0, 5,  32'h12345678, 1);
      add(0, 0, 1, 1, 0, DM, 0,            3'b000, 1, 6,   1, 1, 0, 6,  32'h0000007F, 2);
      add(0, 0, 1, 1, 0, DM, 0,            3'b000, 2, 6,   1, 1, 0, 6,  32'hFFFFFFFF, 3);
      add(0, 0, 1, 1, 0, DM, 0,            3'b100, 3, 6,   1, 1, 0, 6,  32'h00000080, 4);
      add(0, 0, 1, 1, 0, DM, 0,            3'b001, 2, 6,   1, 1, 0, 6,  32'hFFFF80FF, 5);
      add(0, 0, 1, 1, 0, DM, 0,            3'b101, 0, 6,   1, 1, 0, 6,  32'h00007F01, 6);
      add(0, 0, 1, 1, 0, DM, 0,            3'b010, 2, 7,   1, 0, 1, 7,  32'h00000000, 6);
      add(0, 0, 1, 1, 0, DM, 0,            3'b011, 0, 7,   1, 0, 1, 7,  32'h00000000, 6);
      add(0, 0, 1, 1, 1, 0,  32'hDEADBEEF, 3'b000, 0, 0,   1, 0, 0, 0,  32'hDEADBEEF, 6);
      add(0, 0, 1, 1, 2, 0,  0,            3'b000, 0, 8,   1, 1, 0, 8,  X0,           7);
      add(0, 0, 1, 1, 3, 0,  0,            3'b000, 0, 9,   1, 1, 0, 9,  X1,           8);
      add(0, 0, 0, 1, 1, 0,  32'h11111111, 3'b000, 0, 10,  0, 0, 0, 10, 32'h11111111, 8);
      add(0, 0, 1, 1, 0, DM, 0,            3'b010, 0, 11,  1, 1, 0, 11, DM,           9);
      add(0, 0, 1, 0, 1, 0,  32'h22222222, 3'b000, 0, 12,  1, 0, 0, 12, 32'h22222222, 9);
      add(0, 0, 1, 1, 0, DM, 0,            3'b001, 1, 13,  1, 0, 1, 13, 32'h00000000, 9);
      add(0, 0, 1, 1, 0, DM, 0,            3'b101, 3, 13,  1, 0, 1, 13, 32'h00000000, 9);
      add(0, 0, 1, 1, 0, DM, 0,            3'b110, 0, 13,  1, 0, 1, 13, 32'h00000000, 9);
      add(0, 0, 0, 1, 0, DM, 0,            3'b111, 0, 13,  0, 0, 0, 13, 32'h00000000, 9);
      add(0, 0, 1, 1, 1, DM, 32'h33333333, 3'b111, 3, 14,  1, 1, 0, 14, 32'h33333333, 10);
      add(0, 0, 1, 1, 1, 0,  32'hAAAA5555, 3'b000, 0, 15,  1, 1, 0, 15, 32'hAAAA5555, 11);
      add(1, 0, 1, 1, 1, 0,  32'h01010101, 3'b000, 0, 1,   1, 1, 0, 15, 32'hAAAA5555, 11);
      add(1, 0, 1, 1, 0, DM, 0,            3'b010, 1, 2,   1, 1, 0, 15, 32'hAAAA5555, 11);
      add(1, 0, 0, 0, 2, 0,  0,            3'b000, 0, 3,   1, 1, 0, 15, 32'hAAAA5555, 11);
      add(1, 1, 1, 1, 1, 0,  32'h44444444, 3'b000, 0, 4,   0, 0, 0, 15, 32'hAAAA5555, 11);
      add(0, 0, 1, 1, 0, DM, 0,            3'b010, 1, 16,  1, 0, 1, 16, 32'h00000000, 11);
      add(1, 0, 1, 1, 1, 0,  32'h55555555, 3'b000, 0, 17,  1, 0, 0, 16, 32'h00000000, 11);
      add(0, 1, 1, 1, 1, 0,  32'h66666666, 3'b000, 0, 18,  0, 0, 0, 16, 32'h00000000, 11);
      add(0, 0, 1, 1, 1, 0,  32'h00000001, 3'b000, 0, 31,  1, 1, 0, 31, 32'h00000001, 12);

      RST_N = 1'b0;
      if0.DATA_X = {X1, X0};
      drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
      #12;
      chk_zero("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      foreach (vecs[i]) begin
         vec_t v;
         logic [31:0] exp4;
         v = vecs[i];
         drive(v.stall, v.flush, v.valid, v.rw, v.sel, v.dm, v.de, v.fmt, v.alo, v.rd);
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d valid", i), 32'(if0.VALID_OUT),    32'(v.ev));
         chk($sformatf("v%0d we", i),    32'(if0.RF_WE),        32'(v.ewe));
         chk($sformatf("v%0d err", i),   32'(if0.MISALIGN_ERR), 32'(v.eerr));
         chk($sformatf("v%0d addr", i),  32'(if0.RF_ADDR),      32'(v.eaddr));
         chk($sformatf("v%0d data", i),  if0.RF_DATA,           v.edata);
         chk($sformatf("v%0d cnt", i),   if0.RETIRE_CNT,        v.ecnt);
         // NUM_SRC=3 instance: select 3 is out of range there and yields zero.
         exp4 = (v.sel == 2'd3 && !v.stall && !v.flush) ? 32'd0 : v.edata;
         chk($sformatf("v%0d w4 data", i), if4.RF_DATA,         exp4);
         chk($sformatf("v%0d w4 cnt", i),  32'(if4.RETIRE_CNT), 32'(v.ecnt[3:0]));
      end

      // Asynchronous reset while stalled, away from any clock edge.
      @(negedge CLK);
      drive(1, 0, 1, 1, 1, 0, 32'h77777777, 3'b000, 0, 3);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      chk_zero("rst mid-stall");

      // 17 writes after reset: 4-bit counter wraps to 1.
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(0, 0, 1, 1, 1, 0, 32'(i), 3'b000, 0, 5'(i % 31 + 1));
         @(posedge CLK);
         #1;
      end
      chk("wrap cnt32",  if0.RETIRE_CNT,        32'd17);
      chk("wrap cnt4",   32'(if4.RETIRE_CNT),   32'd1);
      chk("wrap data",   if0.RF_DATA,           32'd16);
      chk("wrap addr",   32'(if0.RF_ADDR),      32'd17);

      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 1, 1, 0, 32'hF0F0F0F0, 3'b000, 0, 9);
         @(posedge CLK);
         #1;
      end
      chk("pre-rst cnt4", 32'(if4.RETIRE_CNT), 32'd4);
      #3;
      RST_N = 1'b0;
      #1;
      chk_zero("rst mid-seq");

      @(negedge CLK);
      RST_N = 1'b1;
      drive(0, 0, 1, 1, 1, 0, 32'h0BADF00D, 3'b000, 0, 4);
      @(posedge CLK);
      #1;
      chk("post-rst cnt",  if0.RETIRE_CNT,   32'd1);
      chk("post-rst data", if0.RF_DATA,      32'h0BADF00D);
      chk("post-rst we",   32'(if0.RF_WE),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised, registered writeback stage of the RV32I pipeline; successor to the plain two-input MEM/EX writeback mux.
- Selects one of NUM_SRC result sources and formats load data (byte/half, signed/unsigned, lane-aligned).
- Suppresses writes to x0, detects misaligned loads, and holds one pipeline register with valid/stall/flush control.
- Drives the register-file write port and a retired-write counter.

Parameters:
- XLEN, 32, datapath width (≥ 32, multiple of 8)
- NUM_SRC, 4, number of writeback sources (≥ 2)
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, retired-write counter width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- VALID_IN  in  1  incoming instruction valid
- STALL_IN  in  1  hold the stage register
- FLUSH_IN  in  1  kill the stage contents
- CRT_WB_IN  in  $clog2(NUM_SRC)  source select: 0=DATA_M (load-formatted), 1=DATA_E, k≥2=DATA_X slice k-2
- DATA_M  in  XLEN  raw memory read word
- DATA_E  in  XLEN  ALU result
- DATA_X  in  (NUM_SRC-2)*XLEN  extra sources, flat, slice k-2 at bits [(k-2)*XLEN +: XLEN]
- LOAD_FMT  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- ADDR_LO  in  2  load byte address bits [1:0]
- RD_IN  in  REG_ADDR_W  destination register
- REGWRITE_IN  in  1  instruction writes rd
- RF_WE  out  1  register-file write enable
- RF_ADDR  out  REG_ADDR_W  register-file write address
- RF_DATA  out  XLEN  register-file write data
- VALID_OUT  out  1  stage register holds a valid instruction
- MISALIGN_ERR  out  1  one-cycle pulse: misaligned or illegal-format load captured
- RETIRE_CNT  out  CNT_W  count of committed register writes

Behaviour:
- Reset (RST_N low, asynchronous): every output and internal register is 0.
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- Update priority at each edge:
  1. FLUSH_IN=1: VALID_OUT←0, RF_WE←0, MISALIGN_ERR←0; RF_ADDR/RF_DATA don't-care (hold). Flush wins over stall.
  2. Else STALL_IN=1: all outputs hold, except MISALIGN_ERR←0 (the pulse is not repeated) and RETIRE_CNT, which does not increment.
  3. Else capture: VALID_OUT←VALID_IN; RF_ADDR←RD_IN; RF_DATA←formatted data; RF_WE←VALID_IN & REGWRITE_IN & (RD_IN≠0) & ~err; MISALIGN_ERR←VALID_IN & (CRT_WB_IN==0) & err.
- Source select: CRT_WB_IN ≥ NUM_SRC gives data 0.
- Load formatting, applies only when CRT_WB_IN=0. Lane = DATA_M[8*ADDR_LO +: 8] for bytes, DATA_M[16*ADDR_LO[1] +: 16] for halves.
  - LB sign-extends the byte lane to XLEN; LBU zero-extends it.
  - LH sign-extends the half lane; LHU zero-extends it.
  - LW takes DATA_M[31:0], zero-extended above bit 31 when XLEN>32.
- err conditions (when CRT_WB_IN=0):
  - LH/LHU with ADDR_LO[0]=1
  - LW with ADDR_LO≠0
  - LOAD_FMT in {011, 110, 111}
  - In all err cases, data is 0.
- Sources 1 and up pass through unchanged; LOAD_FMT and ADDR_LO are ignored.
- x0 rule: RD_IN=0 never asserts RF_WE; RF_DATA is still captured.
- RETIRE_CNT increments by 1 on each edge whose captured RF_WE=1. It wraps modulo 2^CNT_W with no saturation.
- Reset mid-stall or mid-flush: reset dominates asynchronously. The first capture is on the first edge after RST_N rises.

Test Plan:
- Reset, then VALID_IN=1, REGWRITE_IN=1, CRT_WB_IN=1, DATA_E=0x12345678, RD_IN=5 -> next cycle RF_WE=1, RF_ADDR=5, RF_DATA=0x12345678, RETIRE_CNT=1.
- CRT_WB_IN=0, DATA_M=0x80FF7F01, LOAD_FMT=000, ADDR_LO=1 -> RF_DATA=0x0000007F; with ADDR_LO=2 -> 0xFFFFFFFF; LBU with ADDR_LO=3 -> 0x00000080; LH with ADDR_LO=2 -> 0xFFFF80FF; LHU with ADDR_LO=0 -> 0x00007F01.
- LW with ADDR_LO=2, RD_IN=7 -> MISALIGN_ERR high exactly one cycle, RF_WE=0, RF_DATA=0, RETIRE_CNT unchanged; repeat with LOAD_FMT=011 -> same.
- RD_IN=0, REGWRITE_IN=1, DATA_E=0xDEADBEEF -> RF_WE=0, RF_DATA=0xDEADBEEF, VALID_OUT=1, RETIRE_CNT unchanged.
- Capture a write, then STALL_IN=1 for 3 cycles while inputs change -> outputs frozen, RETIRE_CNT unchanged. Then FLUSH_IN=1 together with STALL_IN=1 -> VALID_OUT=0, RF_WE=0 next cycle.
- CNT_W=4: perform 17 writes -> RETIRE_CNT=1 (wrap). Then assert RST_N=0 mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
